// File: rtl/card_ddr_rst_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// card_ddr_rst_seq_if : control/status bundle between harness, sequencer, DIMMs
// Revision: 1.0
// ---------------------------------------------------------------------------
interface card_ddr_rst_seq_if #(
  parameter int NUM_CH = 4
);
  logic              start;
  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] cal_done;
  logic [NUM_CH-1:0] dimm_rst_n;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] cal_ok;
  logic [NUM_CH-1:0] cal_fail;

  // master: the sequencer side
  modport master (
    input  start, ch_en, cal_done,
    output dimm_rst_n, busy, done, cal_ok, cal_fail
  );

  modport slave (
    output start, ch_en, cal_done,
    input  dimm_rst_n, busy, done, cal_ok, cal_fail
  );
endinterface
`default_nettype wire

// File: rtl/card_ddr_rst_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// card_ddr_rst_seq : DIMM reset release and calibration-wait sequencer.
// Macro CARD_DDR_RST_SEQ_STAGGER_EN selects one-by-one staggered release.
// Revision: 1.0
// ---------------------------------------------------------------------------
module card_ddr_rst_seq #(
  parameter int NUM_CH          = 4,
  parameter int RST_HOLD_CYC    = 200,
  parameter int STAGGER_CYC     = 16,
  parameter int CAL_TIMEOUT_CYC = 4096,
  parameter int CW              = 16
) (
  input wire clk,
  input wire rst_n,
  card_ddr_rst_seq_if.master bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    RELEASE  = 3'd2,
    WAIT_CAL = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [CW-1:0] c_hold_last  = CW'(RST_HOLD_CYC - 1);
  localparam logic [CW-1:0] c_stag_last  = CW'(STAGGER_CYC - 1);
  localparam logic [CW-1:0] c_cal_last   = CW'(CAL_TIMEOUT_CYC);
  localparam logic [CW-1:0] c_cnt_one    = CW'(1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_chk_num_ch
    $error("card_ddr_rst_seq: NUM_CH must be 1..8");
  end
  if (RST_HOLD_CYC < 1 || STAGGER_CYC < 1 || CAL_TIMEOUT_CYC < 1) begin : g_chk_cyc_min
    $error("card_ddr_rst_seq: cycle parameters must be >= 1");
  end
  if (CW < 31 && (RST_HOLD_CYC >= (1 << CW) || STAGGER_CYC >= (1 << CW) ||
                  CAL_TIMEOUT_CYC >= (1 << CW))) begin : g_chk_cyc_width
    $error("card_ddr_rst_seq: cycle parameters must fit in CW bits");
  end

  state_t            r_state, w_state;
  logic [CW-1:0]     r_cnt, w_cnt;
  logic [NUM_CH-1:0] r_en, w_en;
  logic [NUM_CH-1:0] r_dimm, w_dimm;
  logic [NUM_CH-1:0] r_ok, w_ok;
  logic [NUM_CH-1:0] r_fail, w_fail;
  logic [NUM_CH-1:0] w_ok_qual;
  logic [NUM_CH-1:0] w_pick;
  logic              w_last;

`ifdef CARD_DDR_RST_SEQ_STAGGER_EN
  localparam logic [NUM_CH-1:0] c_ch_one = NUM_CH'(1);
  logic [NUM_CH-1:0] w_pending;

  // Lowest still-held enabled channel; disabled channels never appear here.
  assign w_pending = r_en & ~r_dimm;
  assign w_pick    = w_pending & (~w_pending + c_ch_one);
  assign w_last    = ((w_pending & ~w_pick) == '0);
`else
  assign w_pick    = r_en;
  assign w_last    = 1'b1;
`endif

  // A channel's cal_done only counts once its reset has been released.
  assign w_ok_qual = r_ok | (bus.cal_done & r_dimm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_en    <= '0;
      r_dimm  <= '0;
      r_ok    <= '0;
      r_fail  <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_en    <= w_en;
      r_dimm  <= w_dimm;
      r_ok    <= w_ok;
      r_fail  <= w_fail;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_en    = r_en;
    w_dimm  = r_dimm;
    w_ok    = r_ok;
    w_fail  = r_fail;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_en    = bus.ch_en;
          w_ok    = '0;
          w_fail  = '0;
          w_dimm  = '0;
          w_cnt   = '0;
          w_state = (bus.ch_en != '0) ? HOLD : DONE;
        end
      end
      HOLD: begin
        if (r_cnt == c_hold_last) begin
          w_cnt   = '0;
          w_dimm  = r_dimm | w_pick;
          w_state = w_last ? WAIT_CAL : RELEASE;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      RELEASE: begin
        w_ok = w_ok_qual;
        if (r_cnt == c_stag_last) begin
          w_cnt   = '0;
          w_dimm  = r_dimm | w_pick;
          w_state = w_last ? WAIT_CAL : RELEASE;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      WAIT_CAL: begin
        // Counter is 0 on the last-release cycle, so it reaches the limit
        // exactly CAL_TIMEOUT_CYC cycles later.
        w_ok = w_ok_qual;
        if ((r_ok & r_en) == r_en) begin
          w_state = DONE;
        end else if (r_cnt == c_cal_last) begin
          w_fail  = r_en & ~w_ok_qual;
          w_state = DONE;
        end else begin
          w_cnt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign bus.dimm_rst_n = r_dimm;
  assign bus.busy       = (r_state == HOLD) || (r_state == RELEASE) || (r_state == WAIT_CAL);
  assign bus.done       = (r_state == DONE);
  assign bus.cal_ok     = r_ok;
  assign bus.cal_fail   = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_card_ddr_rst_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_card_ddr_rst_seq : scoreboard bench for the DIMM reset/calibration sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_card_ddr_rst_seq;
  localparam int NCH    = 4;
  localparam int H      = 8;
  localparam int S      = 4;
  localparam int T      = 10;
  localparam int BUDGET = 300;
`ifdef CARD_DDR_RST_SEQ_STAGGER_EN
  localparam bit STAG = 1'b1;
`else
  localparam bit STAG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  card_ddr_rst_seq_if #(.NUM_CH(NCH)) bus ();

  card_ddr_rst_seq #(
    .NUM_CH(NCH), .RST_HOLD_CYC(H), .STAGGER_CYC(S),
    .CAL_TIMEOUT_CYC(T), .CW(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct { int ch; int cyc; } rel_t;
  typedef struct { int cyc; logic [NCH-1:0] ok; logic [NCH-1:0] fail; } fin_t;

  rel_t rel_q[$];
  fin_t fin_q[$];
  int   cal_start[NCH];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [NCH-1:0] cal_vec(input int cyc);
    logic [NCH-1:0] v;
    v = '0;
    for (int i = 0; i < NCH; i++)
      v[i] = (cal_start[i] >= 0) && (cyc >= cal_start[i]);
    return v;
  endfunction

  // Pushes expected releases/result, then runs one sequence from a start pulse.
  task automatic run_seq(input string tag, input logic [NCH-1:0] en,
                         input int pulse_cyc, input int abort_cyc);
    int rel_cyc[NCH];
    int k, last, exit_cyc, done_cyc, smp, max_ok;
    bit all_cal, fin;
    logic [NCH-1:0] e_ok, e_fail, prev, rose;
    rel_t r;
    fin_t f;
    k = 0; last = 0; all_cal = 1'b1; max_ok = 0; e_ok = '0; e_fail = '0;
    for (int i = 0; i < NCH; i++) begin
      rel_cyc[i] = 0;
      if (en[i]) begin
        rel_cyc[i] = STAG ? (1 + H + k * S) : (1 + H);
        last = rel_cyc[i];
        k++;
        r.ch = i; r.cyc = rel_cyc[i];
        rel_q.push_back(r);
        if (cal_start[i] < 0) all_cal = 1'b0;
        else begin
          smp = (cal_start[i] > rel_cyc[i]) ? cal_start[i] : rel_cyc[i];
          if (smp + 1 > max_ok) max_ok = smp + 1;
        end
      end
    end
    exit_cyc = (all_cal && max_ok < last + T) ? max_ok : last + T;
    for (int i = 0; i < NCH; i++) begin
      if (en[i]) begin
        smp = (cal_start[i] > rel_cyc[i]) ? cal_start[i] : rel_cyc[i];
        if (cal_start[i] >= 0 && smp <= exit_cyc) e_ok[i] = 1'b1;
        else e_fail[i] = 1'b1;
      end
    end
    done_cyc = (en == '0) ? 1 : exit_cyc + 1;
    f.cyc = done_cyc; f.ok = e_ok; f.fail = e_fail;
    fin_q.push_back(f);

    @(negedge clk);
    bus.ch_en    = en;
    bus.start    = 1'b1;
    bus.cal_done = cal_vec(0);
    prev = '0;
    fin  = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == pulse_cyc);
      bus.ch_en = (cyc == pulse_cyc) ? '0 : en;
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus.dimm_rst_n, bus.busy, bus.done, bus.cal_ok, bus.cal_fail} !== '0)
          $display("FAIL %s async_reset: dimm=%b busy=%b done=%b ok=%b fail=%b, need all 0",
                   tag, bus.dimm_rst_n, bus.busy, bus.done, bus.cal_ok, bus.cal_fail);
        else n_pass++;
        rel_q.delete();
        fin_q.delete();
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      n_total++;
      if (bus.busy !== ((en != '0) && cyc < done_cyc))
        $display("FAIL %s busy cyc %0d: got %b need %b", tag, cyc, bus.busy,
                 ((en != '0) && cyc < done_cyc));
      else n_pass++;
      n_total++;
      if ((bus.dimm_rst_n & prev) !== prev)
        $display("FAIL %s dimm_reasserted cyc %0d: got %b was %b", tag, cyc, bus.dimm_rst_n, prev);
      else n_pass++;
      rose = bus.dimm_rst_n & ~prev;
      for (int i = 0; i < NCH; i++) begin
        if (rose[i]) begin
          n_total++;
          if (rel_q.size() == 0)
            $display("FAIL %s unexpected_release ch %0d cyc %0d: none expected", tag, i, cyc);
          else begin
            r = rel_q.pop_front();
            if (r.ch != i || r.cyc != cyc)
              $display("FAIL %s release: got ch %0d at cyc %0d, need ch %0d at cyc %0d",
                       tag, i, cyc, r.ch, r.cyc);
            else n_pass++;
          end
        end
      end
      if (bus.done === 1'b1) begin
        fin = 1'b1;
        n_total++;
        if (fin_q.size() == 0)
          $display("FAIL %s unexpected_done cyc %0d", tag, cyc);
        else begin
          f = fin_q.pop_front();
          if (f.cyc != cyc || f.ok !== bus.cal_ok || f.fail !== bus.cal_fail)
            $display("FAIL %s done: got cyc %0d ok=%b fail=%b, need cyc %0d ok=%b fail=%b",
                     tag, cyc, bus.cal_ok, bus.cal_fail, f.cyc, f.ok, f.fail);
          else n_pass++;
        end
        n_total++;
        if (rel_q.size() != 0)
          $display("FAIL %s missing_release: %0d pending, need 0", tag, rel_q.size());
        else n_pass++;
      end
      prev = bus.dimm_rst_n;
      bus.cal_done = cal_vec(cyc);
    end
    if (!fin) begin
      n_total++;
      $display("FAIL %s timeout: done not seen in %0d cycles, need done", tag, BUDGET);
      rel_q.delete();
      fin_q.delete();
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.ch_en = '0; bus.cal_done = '1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if (bus.dimm_rst_n !== '0) $display("FAIL reset dimm_rst_n: got %b need 0", bus.dimm_rst_n);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset busy_done: got %b%b need 00", bus.busy, bus.done);
    else n_pass++;
    n_total++;
    if (bus.cal_ok !== '0 || bus.cal_fail !== '0)
      $display("FAIL reset cal: got ok=%b fail=%b need 0", bus.cal_ok, bus.cal_fail);
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.dimm_rst_n, bus.busy, bus.done} !== '0)
      $display("FAIL idle_after_reset: dimm=%b busy=%b done=%b need all 0",
               bus.dimm_rst_n, bus.busy, bus.done);
    else n_pass++;
  endtask

  task automatic test_all_enabled();
    for (int i = 0; i < NCH; i++) cal_start[i] = 0;
    run_seq("all_en", 4'b1111, -1, -1);
  endtask

  task automatic test_sparse_enable();
    for (int i = 0; i < NCH; i++) cal_start[i] = 0;
    run_seq("sparse_en", 4'b1010, -1, -1);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < NCH; i++) cal_start[i] = 0;
    cal_start[2] = -1;
    run_seq("timeout", 4'b1111, -1, -1);
  endtask

  task automatic test_expiry_boundary();
    int l;
    l = STAG ? (1 + H + 3 * S) : (1 + H);
    cal_start[0] = 0;
    cal_start[1] = 0;
    cal_start[2] = l + T + 1;
    cal_start[3] = l + T;
    run_seq("expiry_edge", 4'b1111, -1, -1);
  endtask

  task automatic test_start_while_busy();
    for (int i = 0; i < NCH; i++) cal_start[i] = 0;
    run_seq("start_busy", 4'b1111, 5, -1);
    run_seq("empty_en", 4'b0000, -1, -1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < NCH; i++) cal_start[i] = 0;
    run_seq("abort", 4'b1111, -1, 1 + H + 1);
    run_seq("post_abort", 4'b1111, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NCH; i++) cal_start[i] = 3;
    run_seq("b2b_a", 4'b0110, -1, -1);
    cal_start[0] = -1;
    run_seq("b2b_b", 4'b1001, -1, -1);
  endtask

  initial begin
    test_reset();
    test_all_enabled();
    test_sparse_enable();
    test_timeout();
    test_expiry_boundary();
    test_start_while_busy();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/card_ddr_rst_seq.md
# card_ddr_rst_seq

Parametrised DDR DIMM reset and calibration sequencer for the card-level simulation model. It drives each channel's DIMM reset and watches each channel's calibration-done flag for up to NUM_CH channels (default 4, A–D). The sequence is: hold all enabled DIMMs in reset, release them in index order with a stagger, then wait for calibration with a timeout and report per-channel pass/fail. It sits beside the `fpga` instance in the card model, between the DIMM models and the test harness.

## Interface
- NUM_CH, 4, number of DDR channels (1..8).
- RST_HOLD_CYC, 200, cycles all enabled DIMM resets are held low after start (≥1).
- STAGGER_CYC, 16, cycles between successive channel releases (≥1).
- CAL_TIMEOUT_CYC, 4096, cycles allowed for calibration after the last release (≥1).
- CW, 16, internal counter width; each cycle parameter must be < 2^CW.

- clk  in  1  sequencer clock; all inputs are synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to run the sequence.
- ch_en  in  NUM_CH  per-channel enable, sampled on the cycle start is accepted.
- cal_done  in  NUM_CH  per-channel calibration-complete level.
- dimm_rst_n  out  NUM_CH  per-channel DIMM reset, active low.
- busy  out  1  sequence in progress.
- done  out  1  sequence complete; results are valid.
- cal_ok  out  NUM_CH  channel calibrated within the timeout.
- cal_fail  out  NUM_CH  enabled channel did not calibrate in time.

## Operation
- FSM states: IDLE, HOLD, RELEASE, WAIT_CAL, DONE.
- Reset values: state IDLE; dimm_rst_n all 0; busy 0; done 0; cal_ok 0; cal_fail 0. Internal counters and the latched enable are cleared.
- IDLE/DONE + start: latch ch_en, clear cal_ok and cal_fail, drive dimm_rst_n all 0, deassert done.
  - If the latched enable is nonzero, enter HOLD.
  - If the latched enable is zero, enter DONE.
- start is ignored while busy.
- HOLD: count RST_HOLD_CYC cycles, then enter RELEASE.
- RELEASE: release enabled channels in ascending index order. Each release sets that channel's dimm_rst_n to 1.
  - Disabled channels are skipped and take no stagger slot.
  - After the highest enabled channel is released, enter WAIT_CAL.
- Disabled channels keep dimm_rst_n=0, cal_ok=0 and cal_fail=0 for the whole run.
- cal_done is qualified only for released channels. A cal_done of 1 before release is ignored.
- While in RELEASE or WAIT_CAL, a qualified cal_done of 1 sets that channel's cal_ok (sticky).
- WAIT_CAL ends on either of two conditions:
  - every enabled channel has cal_ok set (early exit), or
  - CAL_TIMEOUT_CYC cycles have elapsed; each enabled channel without cal_ok then gets cal_fail=1.
- On leaving WAIT_CAL, enter DONE.
- DONE: done=1; results and dimm_rst_n hold until the next start.
- busy = state is HOLD, RELEASE or WAIT_CAL.
- Asserting rst_n low at any point returns every output to its reset value immediately, because reset is asynchronous.

## Timing
- Cycle 0: start sampled high in IDLE/DONE. Cycle 1: busy=1; dimm_rst_n=0 for all channels.
- First enabled channel releases at cycle 1+RST_HOLD_CYC.
- The k-th enabled channel (k from 0) releases at cycle 1+RST_HOLD_CYC+k·STAGGER_CYC.
- Let L be the last release cycle. The WAIT_CAL timeout counter starts at L+1 and expires at L+CAL_TIMEOUT_CYC.
- cal_ok sets the cycle after cal_done is sampled.
- done=1 and busy=0 on the cycle after WAIT_CAL exits.
- Simultaneous events on the timeout-expiry cycle: cal_done=1 sampled on that cycle counts as ok, not fail.
- Empty enable: done=1 at cycle 1, busy stays 0.

## Configuration
- CARD_DDR_RST_SEQ_STAGGER_EN defined: staggered release as described above.
- Macro undefined:
  - all enabled channels release together at cycle 1+RST_HOLD_CYC;
  - STAGGER_CYC is ignored;
  - WAIT_CAL starts the next cycle.

## Test plan
- NUM_CH=4, ch_en=4'b1111, RST_HOLD_CYC=8, STAGGER_CYC=4, macro defined. Start at cycle 0 → channels 0..3 release at cycles 9, 13, 17, 21. With cal_done tied 1, expect cal_ok=4'b1111 and done=1 at cycle 23.
- ch_en=4'b1010, with the same parameters → channel 1 releases at cycle 9 and channel 3 at cycle 13. dimm_rst_n[0] and dimm_rst_n[2] stay 0; cal_ok=4'b1010.
- CAL_TIMEOUT_CYC=10, ch_en=4'b1111, cal_done[2] never asserts → cal_fail=4'b0100, cal_ok=4'b1011, done exactly 10 cycles after the last release plus 1.
- Pulse start while busy, then pulse ch_en=0 → the first pulse is ignored and the sequence is unchanged. The second (empty-enable) run gives done at cycle 1 with all results 0.
- Drop rst_n low mid-RELEASE → all dimm_rst_n return to 0 and busy/done/cal_* to 0 in the same cycle. A new start gives a full, clean sequence.
- Macro undefined, ch_en=4'b1111, RST_HOLD_CYC=8 → all four channels release at cycle 9.
